// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal/vertical counters with sync, visible, fetch and
// logical-pixel outputs, all registered and aligned to the same raster position.
module video_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned FETCH_LEAD = 8,
  parameter int unsigned CW         = 11
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          enable_i,
  input  logic [1:0]    h_rep_i,
  input  logic [1:0]    v_rep_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          visible_o,
  output logic [CW-1:0] h_count_o,
  output logic [CW-1:0] v_count_o,
  output logic [CW-1:0] pix_x_o,
  output logic [CW-1:0] pix_y_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic          fetch_o,
  output logic          fetch_start_o
);

  localparam int unsigned H_OFF   = H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned H_TOTAL = H_OFF + H_VISIBLE;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] HSyncLo  = CW'(H_FRONT);
  localparam logic [CW-1:0] HSyncHi  = CW'(H_FRONT + H_SYNC);
  localparam logic [CW-1:0] HOff     = CW'(H_OFF);
  localparam logic [CW-1:0] HLast    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VVis     = CW'(V_VISIBLE);
  localparam logic [CW-1:0] VSyncLo  = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VSyncHi  = CW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] VLast    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] FetchLo  = CW'(H_OFF - FETCH_LEAD);
  localparam logic [CW-1:0] FetchHi  = CW'(H_TOTAL - FETCH_LEAD - 1);

  if (FETCH_LEAD > H_OFF || FETCH_LEAD < 1 || H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 ||
      H_BACK < 1 || V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      H_TOTAL >= (2 ** CW) || V_TOTAL >= (2 ** CW)) begin : g_bad_params
    $error("video_timing_gen: invalid timing parameters");
  end

  typedef enum logic [1:0] {HPreSync, HSync, HPostSync, HVisible} h_state_e;
  typedef enum logic [1:0] {VVisible, VPreSync, VSync, VPostSync} v_state_e;

  logic          run_q;
  logic          en_q;
  logic [1:0]    hrep_q, vrep_q, hsub_q, vsub_q;
  logic          frame_end, en_eff;
  logic [1:0]    hrep_eff, vrep_eff, hsub_d, vsub_d;
  logic [CW-1:0] h_nxt, v_nxt, pix_x_d, pix_y_d;
  h_state_e      h_st;
  v_state_e      v_st;

  // Outputs are computed from the position the counters move to on this edge, so every
  // registered output describes the same h_count_o/v_count_o.
  always_comb begin
    frame_end = run_q && (h_count_o == HLast) && (v_count_o == VLast);
    en_eff    = frame_end ? enable_i : en_q;
    hrep_eff  = frame_end ? h_rep_i  : hrep_q;
    vrep_eff  = frame_end ? v_rep_i  : vrep_q;

    h_nxt = '0;
    v_nxt = '0;
    if (run_q) begin
      if (h_count_o == HLast) begin
        v_nxt = (v_count_o == VLast) ? '0 : v_count_o + 1'b1;
      end else begin
        h_nxt = h_count_o + 1'b1;
        v_nxt = v_count_o;
      end
    end

    if (h_nxt < HSyncLo)      h_st = HPreSync;
    else if (h_nxt < HSyncHi) h_st = HSync;
    else if (h_nxt < HOff)    h_st = HPostSync;
    else                      h_st = HVisible;

    if (v_nxt < VVis)         v_st = VVisible;
    else if (v_nxt < VSyncLo) v_st = VPreSync;
    else if (v_nxt < VSyncHi) v_st = VSync;
    else                      v_st = VPostSync;

    pix_x_d = '0;
    hsub_d  = '0;
    if (h_st == HVisible && h_nxt != HOff) begin
      if (hsub_q == hrep_eff) begin
        pix_x_d = pix_x_o + 1'b1;
      end else begin
        pix_x_d = pix_x_o;
        hsub_d  = hsub_q + 1'b1;
      end
    end

    pix_y_d = pix_y_o;
    vsub_d  = vsub_q;
    if (h_nxt == '0) begin
      if (v_st == VVisible && v_nxt != '0) begin
        if (vsub_q == vrep_eff) begin
          pix_y_d = pix_y_o + 1'b1;
          vsub_d  = '0;
        end else begin
          vsub_d  = vsub_q + 1'b1;
        end
      end else begin
        pix_y_d = '0;
        vsub_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      run_q         <= 1'b0;
      en_q          <= 1'b0;
      hrep_q        <= '0;
      vrep_q        <= '0;
      hsub_q        <= '0;
      vsub_q        <= '0;
      h_count_o     <= '0;
      v_count_o     <= '0;
      pix_x_o       <= '0;
      pix_y_o       <= '0;
      hsync_o       <= ~H_SYNC_POL;
      vsync_o       <= ~V_SYNC_POL;
      visible_o     <= 1'b0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      fetch_o       <= 1'b0;
      fetch_start_o <= 1'b0;
    end else begin
      // First edge after reset presents position (0,0) rather than advancing past it.
      run_q         <= 1'b1;
      en_q          <= en_eff;
      hrep_q        <= hrep_eff;
      vrep_q        <= vrep_eff;
      hsub_q        <= hsub_d;
      vsub_q        <= vsub_d;
      h_count_o     <= h_nxt;
      v_count_o     <= v_nxt;
      pix_x_o       <= pix_x_d;
      pix_y_o       <= pix_y_d;
      hsync_o       <= (h_st == HSync) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_o       <= (v_st == VSync) ? V_SYNC_POL : ~V_SYNC_POL;
      visible_o     <= en_eff && h_st == HVisible && v_st == VVisible;
      line_start_o  <= h_nxt == '0;
      frame_start_o <= h_nxt == '0 && v_nxt == '0;
      fetch_o       <= en_eff && v_st == VVisible && h_nxt >= FetchLo && h_nxt <= FetchHi;
      fetch_start_o <= en_eff && v_st == VVisible && h_nxt == FetchLo;
    end
  end

endmodule
